// File: rtl/crypto_hdr_tagger_pkg.sv
// crypto_hdr_tagger_pkg: tuser layout, Ethernet/IPv4 constants and FSM encoding shared with the crypto stage
package crypto_hdr_tagger_pkg;

    localparam int TUSER_OFS_LO  = 32;
    localparam int TUSER_OFS_HI  = 39;
    localparam int TUSER_VLD_BIT = 40;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  ETH_HDR_LEN    = 8'd14;

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_BODY  = 1'b1
    } state_t;

    // Returns {valid, payload_offset}; offset is the L4 start (Ethernet + IPv4 header length).
    function automatic logic [8:0] hdr_tag(input logic [15:0] ethertype, input logic [7:0] ver_ihl);
        logic ok;
        ok = (ethertype == ETHERTYPE_IPV4) && (ver_ihl[7:4] == 4'd4) && (ver_ihl[3:0] >= 4'd5);
        return ok ? {1'b1, ETH_HDR_LEN + {2'b00, ver_ihl[3:0], 2'b00}} : 9'd0;
    endfunction

endpackage

// File: rtl/crypto_hdr_tagger_fifo.sv
// fallthrough_small_fifo: small show-ahead FIFO; dout always presents the head entry
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);

    localparam logic [MAX_DEPTH_BITS:0] DEPTH_MAX = (MAX_DEPTH_BITS+1)'(1 << MAX_DEPTH_BITS);
    localparam logic [MAX_DEPTH_BITS:0] DEPTH_NF  = DEPTH_MAX - 1'b1;

    logic [WIDTH-1:0]          mem [1 << MAX_DEPTH_BITS];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;
    logic                      wr;
    logic                      rd;

    assign wr          = wr_en && (depth != DEPTH_MAX);
    assign rd          = rd_en && !empty;
    assign dout        = mem[rd_ptr];
    assign empty       = (depth == '0);
    assign nearly_full = (depth >= DEPTH_NF);

    // storage array, written at the tail
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= din;
    end

    // pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            wr_ptr <= wr_ptr + MAX_DEPTH_BITS'(wr);
            rd_ptr <= rd_ptr + MAX_DEPTH_BITS'(rd);
            depth  <= depth + (MAX_DEPTH_BITS+1)'(wr) - (MAX_DEPTH_BITS+1)'(rd);
        end
    end

endmodule

// File: rtl/crypto_hdr_tagger.sv
// crypto_hdr_tagger: classifies each packet's first beat as IPv4 or other and tags tuser with the payload offset
module crypto_hdr_tagger
    import crypto_hdr_tagger_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                              axis_aclk,
    input  logic                              axis_reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [31:0]                       ipv4_pkt_cnt,
    output logic [31:0]                       other_pkt_cnt
);

    localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int FIFO_W = C_S_AXIS_DATA_WIDTH + KEEP_W + C_S_AXIS_TUSER_WIDTH + 1;

    logic [C_S_AXIS_DATA_WIDTH-1:0]  head_data;
    logic [KEEP_W-1:0]               head_keep;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] head_user;
    logic                            head_last;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] tagged_user;
    logic                            fifo_empty;
    logic                            fifo_nearly_full;
    logic                            pop;
    logic [8:0]                      tag;
    state_t                          state;
    state_t                          state_next;

    assign s_axis_tready = !fifo_nearly_full && !axis_reset;
    assign pop           = !fifo_empty && (!m_axis_tvalid || m_axis_tready);
    assign tag           = hdr_tag({head_data[103:96], head_data[111:104]}, head_data[119:112]);

    fallthrough_small_fifo #(
        .WIDTH          (FIFO_W),
        .MAX_DEPTH_BITS (2)
    ) u_fifo (
        .clk         (axis_aclk),
        .reset       (axis_reset),
        .din         ({s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata}),
        .wr_en       (s_axis_tvalid && s_axis_tready),
        .rd_en       (pop),
        .dout        ({head_last, head_user, head_keep, head_data}),
        .nearly_full (fifo_nearly_full),
        .empty       (fifo_empty)
    );

    // overwrite the tag field only on a packet's first beat
    always_comb begin
        tagged_user = head_user;
        if (state == ST_FIRST) tagged_user[TUSER_VLD_BIT:TUSER_OFS_LO] = tag;
    end

    // packet boundary tracking: advances only on beats leaving the FIFO
    always_comb begin
        state_next = pop ? (head_last ? ST_FIRST : ST_BODY) : state;
    end

    // FSM state register
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) state <= ST_FIRST;
        else            state <= state_next;
    end

    // output register: load on pop, drop valid once the consumer takes the beat
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (pop) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= head_data;
            m_axis_tkeep  <= head_keep;
            m_axis_tuser  <= tagged_user;
            m_axis_tlast  <= head_last;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // per-packet classification counters, bumped when a first beat is loaded
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            ipv4_pkt_cnt  <= '0;
            other_pkt_cnt <= '0;
        end else if (pop && state == ST_FIRST) begin
            if (tag[8]) ipv4_pkt_cnt  <= ipv4_pkt_cnt + 32'd1;
            else        other_pkt_cnt <= other_pkt_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_crypto_hdr_tagger.sv
// tb_crypto_hdr_tagger: directed self-checking bench for crypto_hdr_tagger
module tb_crypto_hdr_tagger;

    logic         axis_aclk = 1'b0;
    logic         axis_reset;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tkeep;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [31:0]  ipv4_pkt_cnt;
    logic [31:0]  other_pkt_cnt;

    int vectors = 0;
    int errors  = 0;

    logic [255:0] rx_d[$];
    logic [127:0] rx_u[$];
    logic [31:0]  rx_k[$];
    logic         rx_l[$];

    logic [255:0] ed[6];
    logic [127:0] eu[6];
    logic [127:0] iu[6];
    logic [255:0] sd;
    logic [127:0] su;
    logic [255:0] d0;
    logic [255:0] d1;
    logic         snd_done;

    localparam logic [127:0] U  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5A5A_F00D;
    localparam logic [127:0] U2 = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;

    crypto_hdr_tagger dut (
        .axis_aclk     (axis_aclk),
        .axis_reset    (axis_reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .ipv4_pkt_cnt  (ipv4_pkt_cnt),
        .other_pkt_cnt (other_pkt_cnt)
    );

    always #5 axis_aclk = ~axis_aclk;

    always @(negedge axis_aclk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            rx_d.push_back(m_axis_tdata);
            rx_u.push_back(m_axis_tuser);
            rx_k.push_back(m_axis_tkeep);
            rx_l.push_back(m_axis_tlast);
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk(input logic [15:0] et, input logic [7:0] b14, input logic [31:0] salt);
        logic [255:0] d;
        d = {8{salt}};
        d[103:96]  = et[15:8];
        d[111:104] = et[7:0];
        d[119:112] = b14;
        return d;
    endfunction

    function automatic logic [127:0] with_tag(input logic [127:0] u, input logic [8:0] t);
        logic [127:0] r;
        r = u;
        r[40:32] = t;
        return r;
    endfunction

    task automatic send(input logic [255:0] d, input logic [127:0] u, input logic l, input logic [31:0] k);
        bit ok = 0;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tkeep  = k;
        s_axis_tvalid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge axis_aclk);
            ok = s_axis_tready;
            @(posedge axis_aclk);
            #1;
        end
        if (!ok) chk("send_timeout", 256'(ok), 256'd1);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        for (int i = 0; i < 200 && rx_d.size() < n; i++) @(negedge axis_aclk);
        repeat (3) @(negedge axis_aclk);
        chk("rx_count", 256'(rx_d.size()), 256'(n));
        @(posedge axis_aclk);
        #1;
    endtask

    task automatic rx_clear();
        rx_d.delete();
        rx_u.delete();
        rx_k.delete();
        rx_l.delete();
    endtask

    initial begin
        axis_reset    = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        snd_done      = 1'b0;
        repeat (3) @(posedge axis_aclk);
        @(negedge axis_aclk);
        chk("rst_s_tready", 256'(s_axis_tready), 256'd0);
        chk("rst_m_tvalid", 256'(m_axis_tvalid), 256'd0);
        chk("rst_m_tdata", m_axis_tdata, 256'd0);
        chk("rst_m_tuser", 256'(m_axis_tuser), 256'd0);
        chk("rst_ipv4_cnt", 256'(ipv4_pkt_cnt), 256'd0);
        chk("rst_other_cnt", 256'(other_pkt_cnt), 256'd0);
        @(posedge axis_aclk);
        #1 axis_reset = 1'b0;
        @(negedge axis_aclk);
        chk("post_rst_s_tready", 256'(s_axis_tready), 256'd1);
        @(posedge axis_aclk);
        #1;

        rx_clear();
        d0 = mk(16'h0800, 8'h45, 32'h1111_0001);
        d1 = {8{32'hBEEF_0002}};
        send(d0, U, 1'b0, '1);
        send(d1, U2, 1'b1, '1);
        wait_rx(2);
        chk("v4_b0_data", rx_d[0], d0);
        chk("v4_b0_user", 256'(rx_u[0]), 256'(with_tag(U, 9'h122)));
        chk("v4_b0_last", 256'(rx_l[0]), 256'd0);
        chk("v4_b1_data", rx_d[1], d1);
        chk("v4_b1_user", 256'(rx_u[1]), 256'(U2));
        chk("v4_b1_last", 256'(rx_l[1]), 256'd1);
        chk("v4_ipv4_cnt", 256'(ipv4_pkt_cnt), 256'd1);
        chk("v4_other_cnt", 256'(other_pkt_cnt), 256'd0);

        rx_clear();
        d0 = mk(16'h0800, 8'h4F, 32'h2222_0003);
        send(d0, U, 1'b1, '1);
        wait_rx(1);
        chk("ihl15_user", 256'(rx_u[0]), 256'(with_tag(U, 9'h14A)));
        chk("ihl15_ipv4_cnt", 256'(ipv4_pkt_cnt), 256'd2);

        rx_clear();
        d0 = mk(16'h0800, 8'h44, 32'h3333_0004);
        send(d0, U, 1'b1, '1);
        wait_rx(1);
        chk("ihl4_user", 256'(rx_u[0]), 256'(with_tag(U, 9'h000)));
        chk("ihl4_other_cnt", 256'(other_pkt_cnt), 256'd1);
        chk("ihl4_ipv4_cnt", 256'(ipv4_pkt_cnt), 256'd2);

        rx_clear();
        d0 = mk(16'h0806, 8'h45, 32'h4444_0005);
        send(d0, U, 1'b1, 32'h0FFF_FFFF);
        wait_rx(1);
        chk("arp_data", rx_d[0], d0);
        chk("arp_keep", 256'(rx_k[0]), 256'h0FFF_FFFF);
        chk("arp_user", 256'(rx_u[0]), 256'(with_tag(U, 9'h000)));
        chk("arp_other_cnt", 256'(other_pkt_cnt), 256'd2);

        rx_clear();
        ed[0] = mk(16'h0800, 8'h45, 32'h5555_0010); iu[0] = U;  eu[0] = with_tag(U, 9'h122);
        ed[1] = {8{32'h5555_0011}};                 iu[1] = U2; eu[1] = U2;
        ed[2] = mk(16'h0800, 8'h4A, 32'h5555_0020); iu[2] = U;  eu[2] = with_tag(U, 9'h136);
        ed[3] = {8{32'h5555_0021}};                 iu[3] = U2; eu[3] = U2;
        ed[4] = mk(16'h0806, 8'h45, 32'h5555_0030); iu[4] = U;  eu[4] = with_tag(U, 9'h000);
        ed[5] = {8{32'h5555_0031}};                 iu[5] = U2; eu[5] = U2;
        m_axis_tready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(ed[i], iu[i], i[0], '1);
                snd_done = 1'b1;
            end
        join_none
        for (int i = 0; i < 50 && !m_axis_tvalid; i++) @(negedge axis_aclk);
        repeat (3) @(negedge axis_aclk);
        sd = m_axis_tdata;
        su = m_axis_tuser;
        chk("bp_head_data", sd, ed[0]);
        chk("bp_head_user", 256'(su), 256'(eu[0]));
        for (int i = 0; i < 10; i++) begin
            @(negedge axis_aclk);
            chk("bp_hold_data", m_axis_tdata, sd);
            chk("bp_hold_user", 256'(m_axis_tuser), 256'(su));
        end
        chk("bp_m_tvalid", 256'(m_axis_tvalid), 256'd1);
        chk("bp_s_tready", 256'(s_axis_tready), 256'd0);
        @(posedge axis_aclk);
        #1 m_axis_tready = 1'b1;
        for (int i = 0; i < 200 && !snd_done; i++) @(negedge axis_aclk);
        chk("bp_sender_done", 256'(snd_done), 256'd1);
        wait_rx(6);
        for (int i = 0; i < 6 && i < rx_d.size(); i++) begin
            chk($sformatf("bp_data%0d", i), rx_d[i], ed[i]);
            chk($sformatf("bp_user%0d", i), 256'(rx_u[i]), 256'(eu[i]));
            chk($sformatf("bp_last%0d", i), 256'(rx_l[i]), 256'(i[0]));
        end
        chk("bp_ipv4_cnt", 256'(ipv4_pkt_cnt), 256'd4);
        chk("bp_other_cnt", 256'(other_pkt_cnt), 256'd3);

        rx_clear();
        m_axis_tready = 1'b0;
        send(mk(16'h0800, 8'h45, 32'h6666_0001), U, 1'b0, '1);
        for (int i = 0; i < 50 && !m_axis_tvalid; i++) @(negedge axis_aclk);
        chk("mid_pkt_tvalid", 256'(m_axis_tvalid), 256'd1);
        @(posedge axis_aclk);
        #3 axis_reset = 1'b1;
        #1;
        chk("async_rst_tvalid", 256'(m_axis_tvalid), 256'd0);
        chk("async_rst_ipv4", 256'(ipv4_pkt_cnt), 256'd0);
        chk("async_rst_other", 256'(other_pkt_cnt), 256'd0);
        chk("async_rst_s_tready", 256'(s_axis_tready), 256'd0);
        repeat (2) @(posedge axis_aclk);
        #1;
        axis_reset    = 1'b0;
        m_axis_tready = 1'b1;
        d0 = mk(16'h0800, 8'h45, 32'h7777_0001);
        send(d0, U, 1'b1, '1);
        wait_rx(1);
        chk("post_rst_user", 256'(rx_u[0]), 256'(with_tag(U, 9'h122)));
        chk("post_rst_data", rx_d[0], d0);
        chk("post_rst_ipv4", 256'(ipv4_pkt_cnt), 256'd1);

        rx_clear();
        @(negedge axis_aclk);
        force dut.ipv4_pkt_cnt = 32'hFFFF_FFFF;
        #1 release dut.ipv4_pkt_cnt;
        @(posedge axis_aclk);
        #1;
        send(mk(16'h0800, 8'h4F, 32'h8888_0001), U, 1'b1, '1);
        wait_rx(1);
        chk("wrap_ipv4_cnt", 256'(ipv4_pkt_cnt), 256'd0);
        chk("wrap_other_cnt", 256'(other_pkt_cnt), 256'd0);
        chk("wrap_user", 256'(rx_u[0]), 256'(with_tag(U, 9'h14A)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/crypto_hdr_tagger.md
CRYPTO_HDR_TAGGER -- requirements
Module: crypto_hdr_tagger

Interface
REQ-001 SHALL have parameter C_M_AXIS_DATA_WIDTH, default 256, output stream data width in bits.
REQ-002 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, input stream data width in bits; must equal C_M_AXIS_DATA_WIDTH.
REQ-003 SHALL have parameter C_M_AXIS_TUSER_WIDTH, default 128, output tuser width.
REQ-004 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, input tuser width.
REQ-005 SHALL have ports: axis_aclk in 1 clock; axis_reset in 1 reset; one clock, reset asynchronous active-high.
REQ-006 SHALL have slave stream ports: s_axis_tdata in 256; s_axis_tkeep in 32; s_axis_tuser in 128; s_axis_tvalid in 1; s_axis_tready out 1; s_axis_tlast in 1.
REQ-007 SHALL have master stream ports: m_axis_tdata out 256; m_axis_tkeep out 32; m_axis_tuser out 128; m_axis_tvalid out 1; m_axis_tready in 1; m_axis_tlast out 1.
REQ-008 SHALL have stats ports: ipv4_pkt_cnt out 32, IPv4 packets tagged; other_pkt_cnt out 32, non-IPv4 or malformed packets.

Function
REQ-009 SHALL buffer input in a 4-entry fall-through FIFO; s_axis_tready = not FIFO nearly_full.
REQ-010 SHALL parse only the first beat of each packet; byte n is tdata[8n+7:8n].
REQ-011 SHALL use ethertype = {byte12, byte13}, version = byte14[7:4], IHL = byte14[3:0].
REQ-012 SHALL classify IPv4 when ethertype = 0x0800, version = 4 and 5 <= IHL <= 15; otherwise "other".
REQ-013 SHALL, for IPv4, set tuser[39:32] = 14 + 4*IHL (34..74), tuser[40] = 1.
REQ-014 SHALL, for other, set tuser[39:32] = 0x00, tuser[40] = 0.
REQ-015 SHALL leave tuser[31:0] and tuser[127:41] unchanged; non-first beats pass tuser unmodified.
REQ-016 SHALL pass tdata, tkeep, tlast unmodified on all beats.
REQ-017 SHALL have FSM states FIRST (next beat is packet start) and BODY; FIRST->BODY on accepted non-last beat; BODY->FIRST on accepted tlast beat; FIRST stays FIRST on accepted single-beat packet.
REQ-018 SHALL register outputs; latency from FIFO head to m_axis_tvalid = 1 cycle.
REQ-019 SHALL load the output register when FIFO non-empty and (m_axis_tvalid = 0 or m_axis_tready = 1), popping the FIFO in that cycle; sustained throughput 1 beat/cycle.
REQ-020 SHALL hold all m_axis_* stable while m_axis_tvalid = 1 and m_axis_tready = 0.
REQ-021 SHALL increment exactly one counter per packet, in the cycle its first beat is loaded into the output register; counters wrap 0xFFFFFFFF->0.
REQ-022 SHALL classify single-beat packets shorter than the computed offset normally (no length check).

Reset
REQ-023 SHALL on axis_reset assertion asynchronously clear m_axis_tvalid, counters and FIFO, set FSM to FIRST; m_axis_tdata/tkeep/tuser/tlast reset to 0.
REQ-024 SHALL drop any partially transferred packet on reset; first beat after release is treated as packet start.
REQ-025 SHALL hold s_axis_tready = 0 while axis_reset is asserted.

Structure
REQ-026 SHALL place tuser field positions (offset [39:32], valid bit 40), ETHERTYPE_IPV4 = 0x0800, ETH_HDR_LEN = 14 and FSM state encodings in a shared package for use by the downstream crypto stage.
REQ-027 SHALL instantiate fallthrough_small_fifo (MAX_DEPTH_BITS = 2) as the sole sub-module.

Verification
REQ-028 SHALL test: 2-beat IPv4 packet, byte12-13 = 08 00, byte14 = 0x45 -> beat 0 tuser[40:32] = 0x122 (valid, offset 34), beat 1 tuser unchanged, ipv4_pkt_cnt = 1.
REQ-029 SHALL test: byte14 = 0x4F -> offset 0x4A (74); byte14 = 0x44 -> tuser[40:32] = 0, other_pkt_cnt increments.
REQ-030 SHALL test: ARP packet ethertype 0x0806 -> tuser[40:32] = 0, data bit-exact.
REQ-031 SHALL test: m_axis_tready held 0 for 10 cycles with 3 back-to-back packets -> outputs stable, no loss/duplication, s_axis_tready drops when FIFO nearly full.
REQ-032 SHALL test: axis_reset asserted mid-packet -> m_axis_tvalid = 0 immediately, counters 0; next packet tagged correctly.
REQ-033 SHALL test: counter preloaded near 0xFFFFFFFF via force -> wraps to 0 after next IPv4 packet.
